// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmit path and its line filter.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INHIBIT,
    BITS,
    ACK
  } state_t;

  localparam int FRAME_BITS = 10;
  localparam int FILTER_W   = 8;

  function automatic logic odd_parity(input logic [7:0] value);
    return ~^value;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmit bundle: request handshake, status pulses and the two open-drain lines.
interface ps2_host_tx_if;

  logic [1:0] ps2;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       send;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output send, tx_data, ps2,
    input  ps2_clk_oe, ps2_dat_oe, busy, done, error
  );

  modport slave (
    input  send, tx_data, ps2,
    output ps2_clk_oe, ps2_dat_oe, busy, done, error
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Debounces the PS/2 clock line over eight ce samples and emits a one-tick falling-edge pulse.
module ps2_line_filter
  import ps2_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic ce,
  input  logic line_i,
  output logic fe_o
);

  logic [FILTER_W-1:0] shift_q, shift_d;
  logic                filt_q, filt_d;
  logic                fe_q, fe_d;

  // The filtered level only flips once the whole window agrees, so glitches never make an edge.
  always_comb begin
    shift_d = shift_q;
    filt_d  = filt_q;
    fe_d    = fe_q;
    if (ce) begin
      shift_d = {shift_q[FILTER_W-2:0], line_i};
      fe_d    = 1'b0;
      if (&shift_q) begin
        filt_d = 1'b1;
      end else if (~|shift_q) begin
        filt_d = 1'b0;
        fe_d   = filt_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '1;
      filt_q  <= 1'b1;
      fe_q    <= 1'b0;
    end else begin
      shift_q <= shift_d;
      filt_q  <= filt_d;
      fe_q    <= fe_d;
    end
  end

  assign fe_o = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, then shifts out data, parity and stop on device edges.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter logic [15:0] INHIBIT_TICKS = 16'd120,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd15000
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          ce,
  ps2_host_tx_if.slave  bus
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BITS - 1);

  state_t                state_q, state_d;
  logic [7:0]            txByte_q, txByte_d;
  logic                  parity_q, parity_d;
  logic [15:0]           tick_q, tick_d;
  logic [3:0]            bitIdx_q, bitIdx_d;
  logic                  clkOe_q, clkOe_d;
  logic                  datOe_q, datOe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  datSync_q;
  logic                  fe;
  logic [FRAME_BITS-1:0] frame;

  ps2_line_filter u_filter (
    .clock   (clock),
    .reset_n (reset_n),
    .ce      (ce),
    .line_i  (bus.ps2[0]),
    .fe_o    (fe)
  );

  assign frame = {1'b1, parity_q, txByte_q};

  always_comb begin
    state_d  = state_q;
    txByte_d = txByte_q;
    parity_d = parity_q;
    tick_d   = tick_q;
    bitIdx_d = bitIdx_q;
    clkOe_d  = clkOe_q;
    datOe_d  = datOe_q;
    busy_d   = busy_q;
    done_d   = done_q;
    error_d  = error_q;
    if (ce) begin
      done_d  = 1'b0;
      error_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.send) begin
            txByte_d = bus.tx_data;
            parity_d = odd_parity(bus.tx_data);
            busy_d   = 1'b1;
            clkOe_d  = 1'b1;
            datOe_d  = 1'b0;
            tick_d   = '0;
            bitIdx_d = '0;
            state_d  = INHIBIT;
          end
        end
        // Start bit goes low one tick before release so the clock stays low for INHIBIT_TICKS in total.
        INHIBIT: begin
          if (!datOe_q) begin
            tick_d = tick_q + 16'd1;
            if (tick_q + 16'd1 == INHIBIT_TICKS - 16'd1) datOe_d = 1'b1;
          end else begin
            clkOe_d  = 1'b0;
            bitIdx_d = '0;
            tick_d   = '0;
            state_d  = BITS;
          end
        end
        BITS, ACK: begin
          if (fe) begin
            tick_d = '0;
            if (state_q == BITS) begin
              datOe_d = ~frame[bitIdx_q];
              if (bitIdx_q == LAST_IDX) state_d = ACK;
              else bitIdx_d = bitIdx_q + 4'd1;
            end else begin
              done_d  = ~datSync_q;
              error_d = datSync_q;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end else if (tick_q + 16'd1 == TIMEOUT_TICKS) begin
            clkOe_d = 1'b0;
            datOe_d = 1'b0;
            error_d = 1'b1;
            busy_d  = 1'b0;
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      txByte_q  <= '0;
      parity_q  <= 1'b0;
      tick_q    <= '0;
      bitIdx_q  <= '0;
      clkOe_q   <= 1'b0;
      datOe_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      datSync_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      txByte_q  <= txByte_d;
      parity_q  <= parity_d;
      tick_q    <= tick_d;
      bitIdx_q  <= bitIdx_d;
      clkOe_q   <= clkOe_d;
      datOe_q   <= datOe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      if (ce) datSync_q <= bus.ps2[1];
    end
  end

  assign bus.ps2_clk_oe = clkOe_q;
  assign bus.ps2_dat_oe = datOe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard clocks frames out of the host and checks them against a frame model.
module tb_ps2_host_tx;

  localparam logic [15:0] INHIBIT = 16'd120;
  localparam logic [15:0] TIMEOUT = 16'd15000;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0;
  logic       devClk = 1'b1;
  logic       devDat = 1'b1;
  logic       ceHold = 1'b0;
  logic       ceRandom = 1'b0;
  logic [9:0] got;

  int checks = 0;
  int failures = 0;
  int tickNo = 0;
  int doneCount = 0;
  int errorCount = 0;
  int bothCount = 0;
  int runLen = 0;
  int lastRun = 0;
  int devLastFall = 0;
  int devEdges = 0;
  logic prevClkOe = 1'b0;
  logic prevDatOe = 1'b0;
  logic lastDatAtFall = 1'b0;

  ps2_host_tx_if bus ();

  assign bus.ps2 = {devDat & ~bus.ps2_dat_oe, devClk & ~bus.ps2_clk_oe};

  ps2_host_tx #(
    .INHIBIT_TICKS (INHIBIT),
    .TIMEOUT_TICKS (TIMEOUT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(negedge clock);
    ce = ceHold ? 1'b0 : (ceRandom ? ($urandom_range(3) != 0) : 1'b1);
  end

  // Tracks pulses and the length of each clock-inhibit window, counted in ce ticks only.
  initial forever begin
    @(posedge clock);
    if (ce) begin
      #1;
      tickNo++;
      if (bus.done) doneCount++;
      if (bus.error) errorCount++;
      if (bus.done && bus.error) bothCount++;
      if (bus.ps2_clk_oe) begin
        runLen++;
        prevDatOe = bus.ps2_dat_oe;
      end else if (prevClkOe) begin
        lastRun = runLen;
        lastDatAtFall = prevDatOe;
        runLen = 0;
      end
      prevClkOe = bus.ps2_clk_oe;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitTick();
    do @(posedge clock); while (ce !== 1'b1);
    #2;
  endtask

  task automatic waitTicks(input int n);
    repeat (n) waitTick();
  endtask

  function automatic logic [9:0] expectFrame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    bus.send = 1'b1;
    bus.tx_data = b;
    waitTick();
    bus.send = 1'b0;
    checkOutput("busy_on_accept", 32'(bus.busy), 32'd1);
  endtask

  // Keyboard model: waits for the start bit, gives 40-tick clock periods and reads each bit while the clock is low.
  task automatic deviceRun(input int nEdges, input bit ackLow, output logic [9:0] bits);
    int budget;
    bits = '0;
    budget = 0;
    while (!(bus.ps2_clk_oe == 1'b0 && bus.ps2_dat_oe == 1'b1) && budget < 2000) begin
      waitTick();
      budget++;
    end
    checkOutput("dev_start_seen", 32'(budget < 2000), 32'd1);
    if (budget >= 2000) return;
    waitTicks(20);
    for (int k = 1; k <= 11 && k <= nEdges; k++) begin
      if (k == 11 && ackLow) devDat = 1'b0;
      devClk = 1'b0;
      devLastFall = tickNo;
      devEdges = k;
      waitTicks(20);
      if (k <= 10) bits[k-1] = bus.ps2[1];
      devClk = 1'b1;
      waitTicks(20);
    end
    devDat = 1'b1;
  endtask

  task automatic runFrame(input logic [7:0] b, input bit ackLow);
    int d0;
    int e0;
    d0 = doneCount;
    e0 = errorCount;
    applyStimulus(b);
    deviceRun(11, ackLow, got);
    checkOutput("frame_bits", 32'(got), 32'(expectFrame(b)));
    checkOutput("inhibit_len", lastRun, 32'(INHIBIT));
    checkOutput("start_before_release", 32'(lastDatAtFall), 32'd1);
    checkOutput("done_pulses", doneCount - d0, ackLow ? 32'd1 : 32'd0);
    checkOutput("error_pulses", errorCount - e0, ackLow ? 32'd0 : 32'd1);
    checkOutput("idle_after_frame", 32'({bus.busy, bus.ps2_clk_oe, bus.ps2_dat_oe}), 32'd0);
  endtask

  initial begin
    int d0;
    int e0;
    int n;
    int delta;
    bus.send = 1'b0;
    bus.tx_data = '0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_outputs",
                32'({bus.ps2_clk_oe, bus.ps2_dat_oe, bus.busy, bus.done, bus.error}), 32'd0);
    @(negedge clock) reset_n = 1'b1;
    waitTicks(5);

    runFrame(8'hED, 1'b1);
    runFrame(8'hF4, 1'b1);
    checkOutput("parity_F4", 32'(got[8]), 32'd0);
    runFrame(8'h00, 1'b1);
    checkOutput("parity_00", 32'(got[8]), 32'd1);

    ceRandom = 1'b1;
    repeat (4) runFrame(8'($urandom), 1'b1);
    runFrame(8'($urandom), 1'b0);
    checkOutput("nack_lines_released", 32'({bus.ps2_clk_oe, bus.ps2_dat_oe}), 32'd0);
    ceRandom = 1'b0;

    // Device goes silent after four edges.
    d0 = doneCount;
    e0 = errorCount;
    applyStimulus(8'h12);
    deviceRun(4, 1'b1, got);
    n = 0;
    while (!bus.error && n < int'(TIMEOUT) + 500) begin
      waitTick();
      n++;
    end
    checkOutput("timeout_error_seen", 32'(bus.error), 32'd1);
    delta = tickNo - devLastFall;
    checkOutput("timeout_window", 32'(delta >= int'(TIMEOUT) && delta <= int'(TIMEOUT) + 15), 32'd1);
    checkOutput("timeout_outputs", 32'({bus.ps2_clk_oe, bus.ps2_dat_oe, bus.busy, bus.done}), 32'd0);
    waitTicks(5);
    checkOutput("timeout_error_once", errorCount - e0, 32'd1);
    checkOutput("timeout_no_done", doneCount - d0, 32'd0);

    // A second request mid-frame must be dropped, not queued.
    d0 = doneCount;
    applyStimulus(8'h3C);
    fork
      deviceRun(11, 1'b1, got);
      begin
        waitTicks(200);
        bus.send = 1'b1;
        bus.tx_data = 8'hC3;
        waitTick();
        bus.send = 1'b0;
        bus.tx_data = '0;
      end
    join
    checkOutput("midsend_frame", 32'(got), 32'(expectFrame(8'h3C)));
    checkOutput("midsend_done", doneCount - d0, 32'd1);
    waitTicks(200);
    checkOutput("midsend_not_queued", 32'({bus.busy, bus.ps2_clk_oe}), 32'd0);

    // Request held across the done tick is taken on the following tick.
    devEdges = 0;
    applyStimulus(8'h81);
    fork
      deviceRun(11, 1'b1, got);
      begin
        n = 0;
        while (devEdges < 11 && n < 2000) begin
          waitTick();
          n++;
        end
        bus.send = 1'b1;
        bus.tx_data = 8'h55;
        n = 0;
        while (!bus.done && n < 200) begin
          waitTick();
          n++;
        end
        checkOutput("done_seen", 32'(bus.done), 32'd1);
        checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
        waitTick();
        checkOutput("accept_after_done", 32'(bus.busy), 32'd1);
        bus.send = 1'b0;
      end
    join
    checkOutput("frame_81", 32'(got), 32'(expectFrame(8'h81)));
    d0 = doneCount;
    deviceRun(11, 1'b1, got);
    checkOutput("frame_55", 32'(got), 32'(expectFrame(8'h55)));
    checkOutput("inhibit_len_55", lastRun, 32'(INHIBIT));
    checkOutput("done_55", doneCount - d0, 32'd1);

    // Long ce stall inside the inhibit window.
    applyStimulus(8'hA5);
    waitTicks(50);
    ceHold = 1'b1;
    repeat (1000) @(posedge clock);
    checkOutput("clk_oe_held_in_stall", 32'(bus.ps2_clk_oe), 32'd1);
    ceHold = 1'b0;
    deviceRun(11, 1'b1, got);
    checkOutput("stall_inhibit_len", lastRun, 32'(INHIBIT));
    checkOutput("stall_frame", 32'(got), 32'(expectFrame(8'hA5)));

    // Asynchronous reset in the middle of the data bits.
    d0 = doneCount;
    e0 = errorCount;
    applyStimulus(8'h96);
    deviceRun(6, 1'b1, got);
    checkOutput("busy_mid_frame", 32'(bus.busy), 32'd1);
    #4 reset_n = 1'b0;
    #1;
    checkOutput("reset_mid_frame",
                32'({bus.ps2_clk_oe, bus.ps2_dat_oe, bus.busy, bus.done, bus.error}), 32'd0);
    repeat (5) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    waitTicks(40);
    checkOutput("reset_no_done", doneCount - d0, 32'd0);
    checkOutput("reset_no_error", errorCount - e0, 32'd0);
    checkOutput("reset_idle", 32'({bus.ps2_clk_oe, bus.ps2_dat_oe, bus.busy}), 32'd0);

    checkOutput("done_error_exclusive", bothCount, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
